// File: rtl/proc_req_arbiter_pkg.sv
// Shared memory-controller definitions: bus width, requester FSM states and access direction.
package proc_req_arbiter_pkg;

    localparam int unsigned BusWidth       = 16;
    localparam int unsigned DefaultTimeout = 64;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitRd,
        StResp
    } req_state_t;

    typedef enum logic {
        RwRead  = 1'b0,
        RwWrite = 1'b1
    } rw_t;

endpackage

// File: rtl/proc_req_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after (last_i + 1) mod N, with wrap.
module proc_req_arbiter_rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] last_i,
    output logic [IdxW-1:0] gnt_idx_o,
    output logic            any_o
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    int unsigned    start;
    int unsigned    sel;

    always_comb begin
        start   = (32'(last_i) + 32'd1) % N;
        req_dbl = {req_i, req_i};
        // Rotate so bit 0 is the highest-priority channel, then take the lowest set bit.
        req_rot = N'(req_dbl >> start);
        sel     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                sel = 32'(i);
            end
        end
        any_o     = |req_i;
        gnt_idx_o = IdxW'((start + sel) % N);
    end

endmodule

// File: rtl/proc_req_arbiter.sv
// Multi-channel processor requester: round-robin pick, one memory transaction at a time, timeout.
module proc_req_arbiter
    import proc_req_arbiter_pkg::*;
#(
    parameter int unsigned NumCh   = 4,
    parameter int unsigned AddrW   = BusWidth,
    parameter int unsigned DataW   = BusWidth,
    parameter int unsigned Timeout = DefaultTimeout
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NumCh-1:0]            ch_req_i,
    input  logic [NumCh-1:0]            ch_rw_i,
    input  logic [NumCh-1:0][AddrW-1:0] ch_addr_i,
    input  logic [NumCh-1:0][DataW-1:0] ch_wdata_i,
    output logic [NumCh-1:0]            ch_ack_o,
    output logic                        ch_err_o,
    output logic [DataW-1:0]            rsp_rdata_o,
    output logic                        mem_req_o,
    output logic                        mem_rw_o,
    output logic [AddrW-1:0]            mem_addr_o,
    output logic [DataW-1:0]            mem_wdata_o,
    input  logic                        mem_gnt_i,
    input  logic                        mem_rvalid_i,
    input  logic [DataW-1:0]            mem_rdata_i
);

    localparam int unsigned IdxW = (NumCh > 1) ? $clog2(NumCh) : 1;
    localparam int unsigned CntW = (Timeout > 1) ? $clog2(Timeout) : 1;
    localparam logic [CntW-1:0] CntLast = (Timeout > 0) ? CntW'(Timeout - 1) : '0;

    req_state_t       state_q, state_d;
    logic [IdxW-1:0]  ch_q, ch_d;
    logic [IdxW-1:0]  last_q, last_d;
    rw_t              rw_q, rw_d;
    logic [AddrW-1:0] addr_q, addr_d;
    logic [DataW-1:0] wdata_q, wdata_d;
    logic [DataW-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic [IdxW-1:0]  gnt_idx;
    logic             any_req;
    logic             timeout_hit;

    proc_req_arbiter_rr_arbiter #(
        .N    (NumCh),
        .IdxW (IdxW)
    ) u_rr_arbiter (
        .req_i     (ch_req_i),
        .last_i    (last_q),
        .gnt_idx_o (gnt_idx),
        .any_o     (any_req)
    );

    assign timeout_hit = (Timeout != 0) && (cnt_q == CntLast);

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        last_d  = last_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    ch_d    = gnt_idx;
                    rw_d    = rw_t'(ch_rw_i[gnt_idx]);
                    addr_d  = ch_addr_i[gnt_idx];
                    wdata_d = ch_wdata_i[gnt_idx];
                    rdata_d = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                // A write grant on the last allowed cycle still completes; a read grant does not.
                if (mem_gnt_i && (rw_q == RwWrite)) begin
                    state_d = StResp;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (mem_gnt_i) begin
                        state_d = StWaitRd;
                    end
                end
            end
            StWaitRd: begin
                if (mem_rvalid_i) begin
                    rdata_d = mem_rdata_i;
                    state_d = StResp;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                last_d  = ch_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // rdata_q stays zero for writes and timeouts, so it can drive the response directly.
    always_comb begin
        ch_ack_o    = '0;
        ch_err_o    = 1'b0;
        rsp_rdata_o = '0;
        mem_req_o   = 1'b0;
        mem_rw_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (state_q == StIssue) begin
            mem_req_o   = 1'b1;
            mem_rw_o    = rw_q;
            mem_addr_o  = addr_q;
            mem_wdata_o = wdata_q;
        end
        if (state_q == StResp) begin
            ch_ack_o[ch_q] = 1'b1;
            ch_err_o       = err_q;
            rsp_rdata_o    = rdata_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            ch_q    <= '0;
            last_q  <= IdxW'(NumCh - 1);
            rw_q    <= RwRead;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            last_q  <= last_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_proc_req_arbiter.sv
// Bench for proc_req_arbiter: transaction-level model checked every cycle plus directed literals.
module tb_proc_req_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int TMO = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NCH-1:0]         ch_req, ch_rw;
    logic [NCH-1:0][AW-1:0] ch_addr;
    logic [NCH-1:0][DW-1:0] ch_wdata;
    logic [NCH-1:0]         ch_ack;
    logic                   ch_err;
    logic [DW-1:0]          rsp_rdata;
    logic                   mem_req, mem_rw;
    logic [AW-1:0]          mem_addr;
    logic [DW-1:0]          mem_wdata;
    logic                   mem_gnt, man_gnt, auto_gnt, mem_rvalid;
    logic [DW-1:0]          mem_rdata;

    assign mem_gnt = auto_gnt ? mem_req : man_gnt;

    proc_req_arbiter #(
        .NumCh   (NCH),
        .AddrW   (AW),
        .DataW   (DW),
        .Timeout (TMO)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .ch_req_i     (ch_req),
        .ch_rw_i      (ch_rw),
        .ch_addr_i    (ch_addr),
        .ch_wdata_i   (ch_wdata),
        .ch_ack_o     (ch_ack),
        .ch_err_o     (ch_err),
        .rsp_rdata_o  (rsp_rdata),
        .mem_req_o    (mem_req),
        .mem_rw_o     (mem_rw),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Transaction-level model: one outstanding transaction, described by its progress flags.
    bit            m_busy, m_granted, m_done, m_err, m_rw;
    int            m_ch, m_last, m_age;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_data;

    logic [NCH-1:0] rec_ack[$];
    bit             rec_err[$];
    logic [DW-1:0]  rec_data[$];
    int             rec_cyc[$];
    logic [AW-1:0]  iss_addr;
    logic [DW-1:0]  iss_wdata;
    bit             e_req;

    logic [NCH-1:0] rr_order[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int             st_ch[2]    = '{3, 1};
    int             st_k[2]     = '{5, 7};
    logic [AW-1:0]  st_addr[2]  = '{16'h0044, 16'h0055};
    logic [DW-1:0]  st_data[2]  = '{16'h003C, 16'h00C3};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy    = 1'b0;
        m_granted = 1'b0;
        m_done    = 1'b0;
        m_err     = 1'b0;
        m_last    = NCH - 1;
        m_data    = '0;
    endtask

    task automatic model_step();
        int  c;
        bit  complete;
        if (m_done) begin
            m_last = m_ch;
            m_busy = 1'b0;
            m_done = 1'b0;
        end else if (!m_busy) begin
            for (int k = 1; k <= NCH; k++) begin
                c = (m_last + k) % NCH;
                if (!m_busy && ch_req[c]) begin
                    m_busy    = 1'b1;
                    m_ch      = c;
                    m_rw      = ch_rw[c];
                    m_addr    = ch_addr[c];
                    m_wdata   = ch_wdata[c];
                    m_age     = 0;
                    m_granted = 1'b0;
                    m_err     = 1'b0;
                    m_data    = '0;
                end
            end
        end else begin
            complete = m_granted ? mem_rvalid : (mem_gnt && m_rw);
            if (complete) begin
                m_done = 1'b1;
                if (m_granted) m_data = mem_rdata;
            end else if (m_age == TMO - 1) begin
                m_done = 1'b1;
                m_err  = 1'b1;
            end else begin
                m_age++;
                if (mem_gnt) m_granted = 1'b1;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                cyc++;
                model_step();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_mem_req", 32'(mem_req), 32'd0);
                chk("rst_ch_ack", 32'(ch_ack), 32'd0);
            end else begin
                e_req = m_busy && !m_granted && !m_done;
                chk("mem_req", 32'(mem_req), 32'(e_req));
                if (e_req) begin
                    chk("mem_rw", 32'(mem_rw), 32'(m_rw));
                    chk("mem_addr", 32'(mem_addr), 32'(m_addr));
                    chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
                    iss_addr  = mem_addr;
                    iss_wdata = mem_wdata;
                end
                chk("ch_ack", 32'(ch_ack), m_done ? (32'd1 << m_ch) : 32'd0);
                if (m_done) begin
                    chk("ch_err", 32'(ch_err), 32'(m_err));
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(m_data));
                end
                if (ch_ack != '0) begin
                    rec_ack.push_back(ch_ack);
                    rec_err.push_back(ch_err);
                    rec_data.push_back(rsp_rdata);
                    rec_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Returns just after the falling edge of the ack cycle, so the requester can still drop.
    task automatic wait_ack(input int budget, input string name);
        int n0;
        n0 = rec_ack.size();
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (rec_ack.size() > n0) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL %s: no ack within %0d cycles", name, budget);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int n0;
        rst_n      = 1'b0;
        ch_req     = '0;
        ch_rw      = '0;
        ch_addr    = '0;
        ch_wdata   = '0;
        man_gnt    = 1'b0;
        auto_gnt   = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        tick(2);
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_ch_ack", 32'(ch_ack), 32'd0);
        chk("reset_ch_err", 32'(ch_err), 32'd0);
        chk("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // Single write on ch1, granted in the first issue cycle.
        ch_rw[1]    = 1'b1;
        ch_addr[1]  = 16'h0010;
        ch_wdata[1] = 16'h00A5;
        man_gnt     = 1'b1;
        ch_req      = 4'b0010;
        t0          = cyc;
        wait_ack(10, "t1_wait");
        ch_req = '0;
        chk("t1_ack", 32'(rec_ack[$]), 32'h2);
        chk("t1_err", 32'(rec_err[$]), 32'd0);
        chk("t1_latency", 32'(rec_cyc[$] - t0), 32'd2);
        chk("t1_mem_addr", 32'(iss_addr), 32'h10);
        chk("t1_mem_wdata", 32'(iss_wdata), 32'hA5);

        // Single read on ch0, rvalid two cycles after the grant.
        tick(1);
        ch_rw[0]   = 1'b0;
        ch_addr[0] = 16'h0020;
        man_gnt    = 1'b1;
        ch_req     = 4'b0001;
        t0         = cyc;
        tick(2);
        man_gnt = 1'b0;
        tick(1);
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h005A;
        wait_ack(6, "t2_wait");
        ch_req     = '0;
        mem_rvalid = 1'b0;
        chk("t2_ack", 32'(rec_ack[$]), 32'h1);
        chk("t2_rdata", 32'(rec_data[$]), 32'h5A);
        chk("t2_err", 32'(rec_err[$]), 32'd0);
        chk("t2_latency", 32'(rec_cyc[$] - t0), 32'd4);

        // Every channel requesting after reset: service order 0,1,2,3,0.
        tick(1);
        rst_n = 1'b0;
        tick(1);
        rst_n    = 1'b1;
        ch_rw    = 4'b1111;
        ch_addr  = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
        ch_wdata = {16'hD3, 16'hD2, 16'hD1, 16'hD0};
        auto_gnt = 1'b1;
        ch_req   = 4'b1111;
        n0       = rec_ack.size();
        for (int i = 0; i < 5; i++) wait_ack(10, "t3_wait");
        ch_req   = '0;
        auto_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_order", 32'(rec_ack[n0 + i]), 32'(rr_order[i]));
        end

        // Read that never sees rvalid; the requester drops early and still gets an error ack.
        tick(1);
        ch_rw[2]   = 1'b0;
        ch_addr[2] = 16'h0030;
        man_gnt    = 1'b1;
        ch_req     = 4'b0100;
        t0         = cyc;
        tick(2);
        man_gnt = 1'b0;
        ch_req  = '0;
        wait_ack(15, "t4_wait");
        chk("t4_ack", 32'(rec_ack[$]), 32'h4);
        chk("t4_err", 32'(rec_err[$]), 32'd1);
        chk("t4_rdata", 32'(rec_data[$]), 32'd0);
        chk("t4_latency", 32'(rec_cyc[$] - (t0 + 1)), 32'd8);
        n0         = rec_ack.size();
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h00EE;
        man_gnt    = 1'b1;
        tick(3);
        mem_rvalid = 1'b0;
        man_gnt    = 1'b0;
        chk("t4_late_rvalid", 32'(rec_ack.size()), 32'(n0));

        // Writes with the grant held off; 7 is the last cycle before the timeout fires.
        for (int i = 0; i < 2; i++) begin
            tick(1);
            man_gnt            = 1'b0;
            ch_rw[st_ch[i]]    = 1'b1;
            ch_addr[st_ch[i]]  = st_addr[i];
            ch_wdata[st_ch[i]] = st_data[i];
            ch_req             = NCH'(1 << st_ch[i]);
            t0                 = cyc;
            tick(1 + st_k[i]);
            man_gnt = 1'b1;
            wait_ack(5, "t5_wait");
            ch_req  = '0;
            man_gnt = 1'b0;
            chk("t5_ack", 32'(rec_ack[$]), 32'd1 << st_ch[i]);
            chk("t5_err", 32'(rec_err[$]), 32'd0);
            chk("t5_latency", 32'(rec_cyc[$] - t0), 32'(st_k[i] + 2));
            chk("t5_mem_addr", 32'(iss_addr), 32'(st_addr[i]));
            chk("t5_mem_wdata", 32'(iss_wdata), 32'(st_data[i]));
        end

        // Reset during a read wait, then the same channel is served; gnt+rvalid together.
        tick(1);
        ch_rw[0]   = 1'b0;
        ch_addr[0] = 16'h0060;
        man_gnt    = 1'b1;
        ch_req     = 4'b0001;
        tick(2);
        man_gnt = 1'b0;
        n0      = rec_ack.size();
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_reset_mem_req", 32'(mem_req), 32'd0);
        chk("t6_reset_ch_ack", 32'(ch_ack), 32'd0);
        tick(1);
        rst_n      = 1'b1;
        t0         = cyc;
        man_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h0077;
        chk("t6_no_ack_on_reset", 32'(rec_ack.size()), 32'(n0));
        wait_ack(10, "t6_wait");
        ch_req     = '0;
        man_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        chk("t6_ack", 32'(rec_ack[$]), 32'h1);
        chk("t6_rdata", 32'(rec_data[$]), 32'h77);
        chk("t6_err", 32'(rec_err[$]), 32'd0);
        chk("t6_latency", 32'(rec_cyc[$] - t0), 32'd3);

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/proc_req_arbiter.md
Name: proc_req_arbiter

Overview:
- Parametrised successor to the single-port processor requester.
- Accepts read/write requests from NUM_CH independent processor channels.
- Arbitrates round-robin and issues one transaction at a time to the memory-controller side over a valid/grant handshake.
- Returns read data and a per-channel acknowledge, with a bounded-wait timeout that reports an error instead of hanging the bus.

Parameters:
- NUM_CH, 4, number of processor channels (2..8).
- ADDR_W, BUSWIDTH, address width, default taken from the shared package.
- DATA_W, BUSWIDTH, data width, default taken from the shared package.
- TIMEOUT, 64, maximum cycles spent in ISSUE+WAIT_RD before abort; 0 disables the timeout.

Ports:
- clk  input  1  single system clock, all logic on rising edge.
- resetN  input  1  asynchronous active-low reset.
- ch_req  input  NUM_CH  per-channel request, held high until that channel's ack.
- ch_rw  input  NUM_CH  per-channel direction, 0 = read, 1 = write.
- ch_addr  input  NUM_CH x ADDR_W  per-channel address.
- ch_wdata  input  NUM_CH x DATA_W  per-channel write data.
- ch_ack  output  NUM_CH  one-cycle completion pulse; one-hot or zero.
- ch_err  output  1  qualifies ch_ack; 1 = timed out.
- rsp_rdata  output  DATA_W  read data, valid in the ch_ack cycle.
- mem_req  output  1  memory request valid.
- mem_rw  output  1  memory direction.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_gnt  input  1  memory accepted the request this cycle.
- mem_rvalid  input  1  read data valid.
- mem_rdata  input  DATA_W  read data.

Behaviour:
- Reset values (asynchronous on resetN low): state IDLE, all outputs 0, last_grant = NUM_CH-1 so channel 0 wins first, timeout counter 0.
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE:
  - If any ch_req is high, select the first requesting channel searching from (last_grant+1) mod NUM_CH upward with wrap.
  - Latch ch index, rw, addr, wdata; go to ISSUE.
  - If no request, stay.
- ISSUE:
  - mem_req=1; mem_rw/addr/wdata driven from the latched values and stable until the grant.
  - On mem_gnt: write goes to RESP; read goes to WAIT_RD.
  - mem_req drops the cycle after the grant.
- WAIT_RD: on mem_rvalid, latch mem_rdata, then go to RESP.
- RESP:
  - ch_ack[latched ch]=1 for exactly one cycle.
  - rsp_rdata = latched data for reads, 0 for writes.
  - last_grant = latched ch; go to IDLE.
- Minimum latency from ch_req to ch_ack: write 3 cycles (gnt in the first ISSUE cycle); read 4 cycles (rvalid the cycle after gnt).
- Back-to-back: after RESP the requester must drop ch_req within the ack cycle. A req still high in IDLE is treated as a new request.
- Timeout:
  - Counter clears on entry to ISSUE and increments each cycle in ISSUE/WAIT_RD.
  - When it reaches TIMEOUT-1 without completion, go to RESP with ch_err=1 and rsp_rdata=0; mem_req deasserts.
  - A stale mem_rvalid/mem_gnt arriving in IDLE or RESP is ignored.
- mem_gnt and mem_rvalid in the same cycle while in ISSUE (read): take the grant only; rvalid is ignored and the block waits in WAIT_RD.
- Requester dropping ch_req mid-transaction: the transaction completes and the ack is still pulsed.
- Inputs of non-selected channels are don't-care; there is no preemption.
- Reset asserted mid-transaction: immediate return to IDLE, mem_req=0, no ack issued.
- NUM_CH=1 degenerates to a single-channel requester with no arbitration change.

Decomposition:
- Shared package mcDefs gains:
  - BUSWIDTH (existing);
  - typedef enum logic[1:0] {IDLE, ISSUE, WAIT_RD, RESP} req_state_t;
  - typedef enum logic {RD=0, WR=1} rw_t;
  - DEFAULT_TIMEOUT.
- One sub-module, rr_arbiter: parameter N; inputs req[N] and last[$clog2(N)]; outputs gnt_idx and any. Purely combinational rotate-and-priority-encode, reused by later multi-port blocks.

Test Plan:
- Single write, ch1, addr 0x10, data 0xA5, gnt in the first ISSUE cycle -> mem_addr=0x10, mem_wdata=0xA5, ch_ack=0010 three cycles after req, ch_err=0.
- Single read, ch0, addr 0x20, rvalid two cycles after gnt with rdata 0x5A -> rsp_rdata=0x5A with ch_ack=0001.
- All four channels request continuously after reset -> grant order 0,1,2,3,0; each ack one-hot; no channel served twice before the others.
- Read with mem_rvalid never asserted, TIMEOUT=8 -> ack with ch_err=1, rsp_rdata=0 at cycle 8 after ISSUE entry; a late rvalid then is ignored.
- resetN pulsed low during WAIT_RD -> mem_req=0, ch_ack=0 immediately; the next request from ch0 is served normally.
- mem_gnt held low for 5 cycles on a write (TIMEOUT=64) -> mem_req/addr/wdata stable throughout; ack follows the grant.
